// File: rtl/z80_cpu_ce_gen.sv
// z80_cpu_ce_gen: CPU clock-enable generator with programmable divider, stall handshake and wait states
`timescale 1ns/1ps
module z80_cpu_ce_gen #(
    parameter int DIV_W     = 4,
    parameter int NUM_STALL = 3,
    parameter int WAIT_W    = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DIV_W-1:0]     div_sel,
    input  logic [NUM_STALL-1:0] stall_req,
    input  logic [NUM_STALL-1:0] stall_mask,
    input  logic                 wait_start,
    input  logic [WAIT_W-1:0]    wait_states,
    output logic                 cpu_ce,
    output logic [NUM_STALL-1:0] stall_ack,
    output logic                 stalled,
    output logic                 wait_active
);
    typedef enum logic [1:0] {S_RUN, S_WAIT, S_STALL} state_t;

    logic [DIV_W-1:0]     r_cnt;
    logic [DIV_W-1:0]     r_div_cur;
    logic [WAIT_W-1:0]    r_wcnt;
    logic                 r_wpend;
    state_t               r_state;
    state_t               r_ret;
    logic [NUM_STALL-1:0] w_live;
    logic                 w_tick;
    logic                 w_act;
    logic                 w_consume;

    assign w_live    = stall_req & ~stall_mask;
    assign w_act     = |w_live;
    assign w_tick    = r_cnt == r_div_cur;
    assign w_consume = w_tick & (r_state == S_RUN) & ~w_act;

    // prescaler; the new ratio is picked up only at a wrap so no period is ever cut short
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_div_cur <= '0;
        end else if (w_tick) begin
            r_cnt     <= '0;
            r_div_cur <= div_sel;
        end else begin
            r_cnt     <= r_cnt + 1'b1;
        end
    end

    // RUN/WAIT/STALL sequencer with registered ce, ack and state decodes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_RUN;
            r_ret       <= S_RUN;
            r_wcnt      <= '0;
            r_wpend     <= 1'b0;
            cpu_ce      <= 1'b0;
            stall_ack   <= '0;
            stalled     <= 1'b0;
            wait_active <= 1'b0;
        end else begin
            cpu_ce    <= 1'b0;
            stall_ack <= (r_state == S_STALL) ? w_live : '0;
            // a pulse coinciding with the consuming tick re-arms for the following tick
            r_wpend   <= wait_start | (r_wpend & ~w_consume);
            if (w_tick) begin
                case (r_state)
                    S_RUN: begin
                        if (w_act) begin
                            r_state <= S_STALL;
                            r_ret   <= S_RUN;
                            stalled <= 1'b1;
                        end else begin
                            cpu_ce <= 1'b1;
                            if (r_wpend && wait_states != '0) begin
                                r_wcnt      <= wait_states;
                                r_state     <= S_WAIT;
                                wait_active <= 1'b1;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (w_act) begin
                            r_state     <= S_STALL;
                            r_ret       <= S_WAIT;
                            stalled     <= 1'b1;
                            wait_active <= 1'b0;
                        end else begin
                            r_wcnt <= r_wcnt - 1'b1;
                            if (r_wcnt == WAIT_W'(1)) begin
                                r_state     <= S_RUN;
                                wait_active <= 1'b0;
                            end
                        end
                    end
                    S_STALL: begin
                        if (!w_act) begin
                            r_state     <= r_ret;
                            stalled     <= 1'b0;
                            wait_active <= r_ret == S_WAIT;
                        end
                    end
                    default: begin
                        r_state     <= S_RUN;
                        stalled     <= 1'b0;
                        wait_active <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/z80_cpu_ce_gen.md
# z80_cpu_ce_gen

Parametrised clock-enable generator for the Z80 core. It replaces gated-clock CPU clocking with a single-cycle `cpu_ce` pulse train derived from the system clock. It offers a programmable divide ratio, an N-channel stall request/acknowledge handshake (DMA, SDRAM, video) and automatic memory wait-state insertion. It sits between the CPU core's clock-enable input and the bus masters that must freeze it.

## Interface
- `DIV_W`, 4, width of divide-ratio select
- `NUM_STALL`, 3, number of stall request channels
- `WAIT_W`, 3, width of wait-state count
- `clk`  in  1  system clock; the only clock
- `reset_n`  in  1  reset, asynchronous and active-low
- `div_sel`  in  DIV_W  ticks occur every `div_sel+1` clk cycles
- `stall_req`  in  NUM_STALL  per-channel level request to freeze CPU
- `stall_mask`  in  NUM_STALL  1 = ignore that channel
- `wait_start`  in  1  single-cycle pulse at CPU memory cycle start
- `wait_states`  in  WAIT_W  number of ticks to withhold after `wait_start`
- `cpu_ce`  out  1  registered one-cycle clock enable to CPU
- `stall_ack`  out  NUM_STALL  per-channel grant: CPU frozen
- `stalled`  out  1  state is STALL
- `wait_active`  out  1  state is WAIT

## Operation
- Prescaler `cnt` (DIV_W bits) counts 0..`div_cur`. A tick occurs when `cnt==div_cur`; `cnt` then wraps to 0 and `div_cur` loads `div_sel`. `div_sel` changes take effect only at a wrap; no runt periods.
- Active stall `act = |(stall_req & ~stall_mask)`, evaluated only on tick cycles.
- `wait_start` is latched into `wpend` and held until consumed at the next tick in RUN.
- States RUN, WAIT, STALL; reset to RUN. Tick-cycle behaviour:
  - RUN: if `act`, go to STALL with `ret`=RUN and no ce. Else if `wpend` and `wait_states!=0`, issue ce, load `wcnt=wait_states`, clear `wpend` and go to WAIT. Else if `wpend` and `wait_states==0`, issue ce and clear `wpend`. Else issue ce.
  - WAIT: if `act`, go to STALL with `ret`=WAIT; `wcnt` is held. Else decrement `wcnt` with no ce; on `wcnt==1`, go to RUN.
  - STALL: no ce. If `!act`, return to `ret`. The exit tick issues no ce, so the first ce comes one tick later.
- Stall has priority over wait. Wait progress is frozen, not lost, across a stall.
- `stall_ack[i]` is registered: `(state==STALL) & stall_req[i] & ~stall_mask[i]`. It drops the cycle after its request drops or it is masked.
- Masking a channel mid-stall releases that channel only. The CPU resumes only when all unmasked requests are low.

## Timing
- Reset values: `cnt=0`, `div_cur=0`, state RUN, `wcnt=0`, `wpend=0`, `cpu_ce=0`, `stall_ack=0`, `stalled=0`, `wait_active=0`.
- First tick is on the first clk edge after reset release (`div_cur=0`), so `cpu_ce` is first high in the second cycle.
- `cpu_ce` latency: high for exactly one cycle, in the cycle after the tick cycle. It is never high in two consecutive cycles unless `div_cur=0`.
- Stall latency: a request raised in a non-tick cycle suppresses the next tick. `stall_ack` rises one cycle after the state enters STALL. Worst case from request to ack is `div_cur+2` cycles.
- A request is safe only after `stall_ack`. The requester must hold `stall_req` until it finishes.
- A `wait_start` simultaneous with a tick is latched and applies to the following tick, not the current one.
- Reset asserted mid-stall or mid-wait returns all outputs to reset values immediately (asynchronous). `stall_ack` drops without handshake.
- `stalled` and `wait_active` are registered decodes of the state, valid in the cycle after each transition.

## Test plan
- Free run: `div_sel=3`, no requests -> `cpu_ce` pulses every 4 cycles, 1 cycle wide; first pulse in cycle 2 after reset.
- Divider change: switch `div_sel` from 3 to 1 mid-period -> the current 4-cycle period completes, then pulses come every 2 cycles, with no short period.
- Wait states: `div_sel=1`, `wait_states=2`, one `wait_start` pulse -> ce at the consuming tick, two ticks with no ce and `wait_active=1`, then normal.
- Stall handshake: `stall_req=3'b010` held 20 cycles, `div_sel=3` -> no ce after the next tick, `stall_ack=3'b010` one cycle after STALL. After release, ack drops in 1 cycle and the first ce comes two ticks later.
- Stall during wait: `wait_states=3`, stall raised after 1 wait tick, released later -> exactly 2 further no-ce wait ticks after the stall, then RUN.
- Masking and reset: `stall_req=3'b101`, then set `stall_mask=3'b001` -> `stall_ack=3'b100` and the CPU stays stalled. Assert `reset_n=0` mid-stall -> all outputs 0 asynchronously.
